pac_motion: RTL and testbench
=============================

Name: pac_motion

Overview:
- Pac-Man motion controller and sprite-window generator; sits directly upstream of the Pac-Man sprite ROM stage.
- Latches joystick direction requests and steps Pac-Man one pixel per move tick on a 24-px tile grid.
- Checks the next tile against the wall map through a req/ack handshake.
- From the VGA scan counters, produces the sprite-local x/y, in-window flag and facing direction consumed by the sprite ROM.

Parameters:
- STEP_DIV, 500000: clocks per move tick.
- COLS, 26: grid columns (24 px tiles).
- ROWS, 20: grid rows.
- START_COL, 12: reset tile column.
- START_ROW, 15: reset tile row.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- key_dir  in  4  requested direction, one-hot L=1000 U=0100 R=0010 D=0001
- h_cnt  in  10  VGA horizontal scan pixel
- v_cnt  in  10  VGA vertical scan pixel
- wall_req  out  1  one-cycle wall query strobe
- wall_col  out  5  queried tile column, held until ack
- wall_row  out  5  queried tile row, held until ack
- wall_ack  in  1  wall answer valid
- wall_hit  in  1  1 = queried tile is wall, sampled with wall_ack
- pac_x  out  10  sprite top-left pixel x
- pac_y  out  10  sprite top-left pixel y
- dir  out  4  facing direction to sprite stage, 0000 = none yet
- moving  out  1  1 while advancing
- in_sprite  out  1  scan pixel inside 24x24 sprite window
- sprite_x  out  5  h_cnt - pac_x, 0 when outside window
- sprite_y  out  5  v_cnt - pac_y, 0 when outside window

Behaviour:
- Reset values: pac_x = START_COL*24, pac_y = START_ROW*24; dir, pending and moving = 0; wall_req = 0; wall_col/wall_row = 0; sprite outputs 0; tick counter 0; offset 0; state IDLE.
- Tick counter runs 0..STEP_DIV-1 and pulses tick on wrap. A tick arriving outside IDLE is dropped.
- key_dir with exactly one bit set loads pending. Zero or multi-bit values are ignored; pending holds.
- offset (0..23) = pixels travelled since the last tile boundary. Aligned ⇔ offset == 0.
- FSM states: IDLE, QRY_P, WAIT_P, QRY_C, WAIT_C, STEP.
  - IDLE + tick:
    - not aligned → STEP;
    - aligned, pending != 0 and pending != dir → QRY_P;
    - aligned, dir != 0 → QRY_C;
    - otherwise stay IDLE.
  - QRY_x: compute neighbour tile in the candidate direction.
    - Neighbour outside 0..COLS-1 / 0..ROWS-1 counts as a hit; no wall_req is issued.
    - Otherwise assert wall_req for 1 cycle with wall_col/wall_row, then go to WAIT_x.
  - WAIT_x: hold until wall_ack (latency ≥1, unbounded).
  - WAIT_P result:
    - miss → dir = pending, pending = 0, moving = 1, go to STEP;
    - hit → QRY_C if dir != 0, else IDLE.
  - WAIT_C result:
    - miss → moving = 1, go to STEP;
    - hit → moving = 0, go to IDLE; dir is kept for facing.
  - STEP: pac_x/pac_y ±1 in dir, offset = (offset+1) mod 24, return to IDLE. The move is visible the cycle after STEP.
- wall_ack outside WAIT_x is ignored.
- Reset mid-handshake abandons the query; a late ack is ignored.
- Sprite window is registered with 1-cycle latency:
  - in_sprite = (pac_x ≤ h_cnt < pac_x+24) && (pac_y ≤ v_cnt < pac_y+24);
  - sprite_x/sprite_y = low 5 bits of the differences when in_sprite, else 0;
  - compare at 11-bit width so pac_x+24 cannot wrap.

Optional Feature:
- PAC_REVERSE_EN defined: in IDLE on a tick, if pending is the exact opposite of dir and not aligned:
  - no wall query;
  - dir = opposite, pending = 0;
  - offset = 24 - offset;
  - go to STEP.
- PAC_REVERSE_EN undefined: reversal waits for alignment like any other turn.

Test Plan:
- Reset with STEP_DIV=4 → pac_x=288, pac_y=360, dir=0000, moving=0, wall_req=0; ticks with no key → no wall_req ever.
- key_dir=0010, every ack wall_hit=0 → one req per tile at (13,15), (14,15), …; after 24 steps pac_x=312, dir=0010, moving=1.
- While moving R mid-tile, key_dir=0100; at alignment answer hit for (x,14), then miss for R → two reqs in order; dir stays 0010; pending stays 0100.
- Start col forced 0, key_dir=1000 → no wall_req; moving=0; dir=0000; pac_x unchanged.
- pac_x=48, pac_y=24; h_cnt=50, v_cnt=30 → next cycle in_sprite=1, sprite_x=2, sprite_y=6. h_cnt=72 → in_sprite=0, sprite_x=0.
- rst in WAIT_P, then late wall_ack=1 → state IDLE, pac position at reset values, no move. With PAC_REVERSE_EN: moving R at offset 5, key 1000 → no req; dir=1000; pac_x decrements next step.

Source files
------------

// File: rtl/pac_motion.sv
// Pac-Man grid motion controller: tick-paced stepping, wall-map query handshake, sprite window.
// Define PAC_REVERSE_EN to allow an instant mid-tile reversal without a wall query.
module pac_motion #(
    parameter int STEP_DIV  = 500000,
    parameter int COLS      = 26,
    parameter int ROWS      = 20,
    parameter int START_COL = 12,
    parameter int START_ROW = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_dir,
    input  logic [9:0] h_cnt,
    input  logic [9:0] v_cnt,
    output logic       wall_req,
    output logic [4:0] wall_col,
    output logic [4:0] wall_row,
    input  logic       wall_ack,
    input  logic       wall_hit,
    output logic [9:0] pac_x,
    output logic [9:0] pac_y,
    output logic [3:0] dir,
    output logic       moving,
    output logic       in_sprite,
    output logic [4:0] sprite_x,
    output logic [4:0] sprite_y
);
    localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [3:0] DIR_L = 4'b1000;
    localparam logic [3:0] DIR_U = 4'b0100;
    localparam logic [3:0] DIR_R = 4'b0010;
    localparam logic [3:0] DIR_D = 4'b0001;

    typedef enum logic [2:0] {IDLE, QRY_P, WAIT_P, QRY_C, WAIT_C, STEP} state_t;

    state_t        state_q;
    logic [CW-1:0] tickCnt_q, tickCnt_d;
    logic [9:0]    pacX_q, pacY_q;
    logic [3:0]    dir_q, pending_q;
    logic          moving_q, wallReq_q;
    logic [4:0]    wallCol_q, wallRow_q;
    logic [4:0]    tileCol_q, tileRow_q;
    logic [4:0]    offset_q;
    logic          inSprite_q;
    logic [4:0]    spriteX_q, spriteY_q;

    logic          tick, aligned, nbrOut, inWin;
    logic [3:0]    cand;
    logic [4:0]    nbrCol, nbrRow, stepCol, stepRow;
    logic [10:0]   hx, vy, px, py;

`ifdef PAC_REVERSE_EN
    function automatic logic [3:0] opposite(input logic [3:0] d);
        return {d[1], d[0], d[3], d[2]};
    endfunction
`endif

    assign tick      = (tickCnt_q == CW'(STEP_DIV - 1));
    assign tickCnt_d = tick ? '0 : tickCnt_q + CW'(1);
    assign aligned   = (offset_q == 5'd0);

    // Neighbour of the current tile in the candidate direction; off-grid reads as a wall.
    always_comb begin
        cand    = (state_q == QRY_P) ? pending_q : dir_q;
        nbrCol  = tileCol_q;
        nbrRow  = tileRow_q;
        nbrOut  = 1'b0;
        case (cand)
            DIR_L: if (tileCol_q == 5'd0) nbrOut = 1'b1; else nbrCol = tileCol_q - 5'd1;
            DIR_R: if (tileCol_q == 5'(COLS - 1)) nbrOut = 1'b1; else nbrCol = tileCol_q + 5'd1;
            DIR_U: if (tileRow_q == 5'd0) nbrOut = 1'b1; else nbrRow = tileRow_q - 5'd1;
            DIR_D: if (tileRow_q == 5'(ROWS - 1)) nbrOut = 1'b1; else nbrRow = tileRow_q + 5'd1;
            default: nbrOut = 1'b1;
        endcase
    end

    // Tile reached by crossing the next boundary in the facing direction.
    always_comb begin
        stepCol = tileCol_q;
        stepRow = tileRow_q;
        case (dir_q)
            DIR_L:   stepCol = tileCol_q - 5'd1;
            DIR_R:   stepCol = tileCol_q + 5'd1;
            DIR_U:   stepRow = tileRow_q - 5'd1;
            DIR_D:   stepRow = tileRow_q + 5'd1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tickCnt_q <= '0;
            pacX_q    <= 10'(START_COL * 24);
            pacY_q    <= 10'(START_ROW * 24);
            dir_q     <= 4'b0;
            pending_q <= 4'b0;
            moving_q  <= 1'b0;
            wallReq_q <= 1'b0;
            wallCol_q <= 5'd0;
            wallRow_q <= 5'd0;
            tileCol_q <= 5'(START_COL);
            tileRow_q <= 5'(START_ROW);
            offset_q  <= 5'd0;
        end else begin
            tickCnt_q <= tickCnt_d;
            wallReq_q <= 1'b0;
            case (state_q)
                IDLE: if (tick) begin
`ifdef PAC_REVERSE_EN
                    // Reversing mid-tile: the boundary behind becomes the reference tile.
                    if (!aligned && dir_q != 4'b0 && pending_q == opposite(dir_q)) begin
                        dir_q     <= pending_q;
                        pending_q <= 4'b0;
                        offset_q  <= 5'd24 - offset_q;
                        tileCol_q <= stepCol;
                        tileRow_q <= stepRow;
                        state_q   <= STEP;
                    end else
`endif
                    if (!aligned)                                   state_q <= STEP;
                    else if (pending_q != 4'b0 && pending_q != dir_q) state_q <= QRY_P;
                    else if (dir_q != 4'b0)                           state_q <= QRY_C;
                end
                QRY_P, QRY_C: begin
                    if (nbrOut) begin
                        if (state_q == QRY_P) begin
                            state_q <= (dir_q != 4'b0) ? QRY_C : IDLE;
                        end else begin
                            moving_q <= 1'b0;
                            state_q  <= IDLE;
                        end
                    end else begin
                        wallReq_q <= 1'b1;
                        wallCol_q <= nbrCol;
                        wallRow_q <= nbrRow;
                        state_q   <= (state_q == QRY_P) ? WAIT_P : WAIT_C;
                    end
                end
                WAIT_P: if (wall_ack) begin
                    if (!wall_hit) begin
                        dir_q     <= pending_q;
                        pending_q <= 4'b0;
                        moving_q  <= 1'b1;
                        state_q   <= STEP;
                    end else begin
                        state_q <= (dir_q != 4'b0) ? QRY_C : IDLE;
                    end
                end
                WAIT_C: if (wall_ack) begin
                    moving_q <= !wall_hit;
                    state_q  <= wall_hit ? IDLE : STEP;
                end
                STEP: begin
                    case (dir_q)
                        DIR_L:   pacX_q <= pacX_q - 10'd1;
                        DIR_R:   pacX_q <= pacX_q + 10'd1;
                        DIR_U:   pacY_q <= pacY_q - 10'd1;
                        DIR_D:   pacY_q <= pacY_q + 10'd1;
                        default: ;
                    endcase
                    if (offset_q == 5'd23) begin
                        offset_q  <= 5'd0;
                        tileCol_q <= stepCol;
                        tileRow_q <= stepRow;
                    end else begin
                        offset_q <= offset_q + 5'd1;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if ($onehot(key_dir)) pending_q <= key_dir;
        end
    end

    // Window compare is 11 bits wide so pac+24 never wraps; low 5 bits of the difference suffice.
    assign hx    = {1'b0, h_cnt};
    assign vy    = {1'b0, v_cnt};
    assign px    = {1'b0, pacX_q};
    assign py    = {1'b0, pacY_q};
    assign inWin = (hx >= px) && (hx < px + 11'd24) && (vy >= py) && (vy < py + 11'd24);

    always_ff @(posedge clk) begin
        if (rst) begin
            inSprite_q <= 1'b0;
            spriteX_q  <= 5'd0;
            spriteY_q  <= 5'd0;
        end else begin
            inSprite_q <= inWin;
            spriteX_q  <= inWin ? (h_cnt[4:0] - pacX_q[4:0]) : 5'd0;
            spriteY_q  <= inWin ? (v_cnt[4:0] - pacY_q[4:0]) : 5'd0;
        end
    end

    assign wall_req  = wallReq_q;
    assign wall_col  = wallCol_q;
    assign wall_row  = wallRow_q;
    assign pac_x     = pacX_q;
    assign pac_y     = pacY_q;
    assign dir       = dir_q;
    assign moving    = moving_q;
    assign in_sprite = inSprite_q;
    assign sprite_x  = spriteX_q;
    assign sprite_y  = spriteY_q;
endmodule

// File: tb/tb_pac_motion.sv
// Scoreboard bench for pac_motion: expected wall queries are queued, a monitor pops and answers them.
module tb_pac_motion;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_dir = 4'b0, key2 = 4'b0;
    logic [9:0] h_cnt = 10'd0, v_cnt = 10'd0;
    logic       wall_ack = 1'b0, wall_hit = 1'b0;

    logic       wall_req, moving, in_sprite;
    logic [4:0] wall_col, wall_row, sprite_x, sprite_y;
    logic [9:0] pac_x, pac_y;
    logic [3:0] dir;

    logic       req2, mov2, ins2;
    logic [4:0] col2, row2, sx2, sy2;
    logic [9:0] px2, py2;
    logic [3:0] dir2;

    logic       req3, mov3, ins3;
    logic [4:0] col3, row3, sx3, sy3;
    logic [9:0] px3, py3;
    logic [3:0] dir3;

    typedef struct packed {logic [4:0] col; logic [4:0] row; logic hit;} req_t;
    req_t expQ[$];

    int   errors = 0, checks = 0;
    int   reqCount = 0, reqCount2 = 0;
    int   ackWait = 0, lateAckCnt = 0, lateAckDone = 0;
    logic autoAck = 1'b1, pendHit = 1'b0;

    always #5 clk = ~clk;

    pac_motion #(.STEP_DIV(4)) dut (
        .clk(clk), .rst(rst), .key_dir(key_dir), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .wall_req(wall_req), .wall_col(wall_col), .wall_row(wall_row),
        .wall_ack(wall_ack), .wall_hit(wall_hit), .pac_x(pac_x), .pac_y(pac_y),
        .dir(dir), .moving(moving), .in_sprite(in_sprite),
        .sprite_x(sprite_x), .sprite_y(sprite_y));

    pac_motion #(.STEP_DIV(4), .START_COL(0)) dutEdge (
        .clk(clk), .rst(rst), .key_dir(key2), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .wall_req(req2), .wall_col(col2), .wall_row(row2),
        .wall_ack(1'b0), .wall_hit(1'b0), .pac_x(px2), .pac_y(py2),
        .dir(dir2), .moving(mov2), .in_sprite(ins2), .sprite_x(sx2), .sprite_y(sy2));

    pac_motion #(.STEP_DIV(4), .START_COL(2), .START_ROW(1)) dutSpr (
        .clk(clk), .rst(rst), .key_dir(4'b0), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .wall_req(req3), .wall_col(col3), .wall_row(row3),
        .wall_ack(1'b0), .wall_hit(1'b0), .pac_x(px3), .pac_y(py3),
        .dir(dir3), .moving(mov3), .in_sprite(ins3), .sprite_x(sx3), .sprite_y(sy3));

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] k1, input logic [3:0] k2);
        @(negedge clk);
        key_dir = k1;
        key2    = k2;
        @(negedge clk);
        key_dir = 4'b0;
        key2    = 4'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitPac(input logic [9:0] target, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (pac_x == target) break;
        end
        if (i == budget) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_pac_x actual=%0d expected=%0d", pac_x, target);
        end
    endtask

    task automatic waitReq(input int target, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (reqCount >= target) break;
        end
        if (i == budget) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_req actual=%0d expected=%0d", reqCount, target);
        end
    endtask

    task automatic applySprite(input logic [9:0] h, input logic [9:0] v,
                               input logic expIn, input logic [4:0] expX, input logic [4:0] expY);
        @(negedge clk);
        h_cnt = h;
        v_cnt = v;
        @(negedge clk);
        checkOutput("in_sprite", 32'(ins3), 32'(expIn));
        checkOutput("sprite_x", 32'(sx3), 32'(expX));
        checkOutput("sprite_y", 32'(sy3), 32'(expY));
    endtask

    // Monitor and wall-map responder: acks two cycles after each observed request.
    initial begin
        req_t e;
        forever begin
            @(negedge clk);
            wall_ack = 1'b0;
            wall_hit = 1'b0;
            if (ackWait > 0) begin
                ackWait--;
                if (ackWait == 0) begin
                    wall_ack = 1'b1;
                    wall_hit = pendHit;
                end
            end
            if (lateAckCnt != lateAckDone) begin
                lateAckDone++;
                wall_ack = 1'b1;
            end
            if (req2) reqCount2++;
            if (wall_req) begin
                reqCount++;
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_req actual=(%0d,%0d) expected=none", wall_col, wall_row);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("req_tile", 32'({wall_col, wall_row}), 32'({e.col, e.row}));
                    if (autoAck) begin
                        ackWait = 2;
                        pendHit = e.hit;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        waitCycles(3);
        rst = 1'b0;
        checkOutput("rst_pac_x", 32'(pac_x), 32'd288);
        checkOutput("rst_pac_y", 32'(pac_y), 32'd360);
        checkOutput("rst_dir", 32'(dir), 32'd0);
        checkOutput("rst_moving", 32'(moving), 32'd0);
        checkOutput("rst_wall_req", 32'(wall_req), 32'd0);
        checkOutput("rst_wall_col", 32'(wall_col), 32'd0);
        checkOutput("rst_in_sprite", 32'(in_sprite), 32'd0);
        waitCycles(40);
        checkOutput("idle_no_req", 32'(reqCount), 32'd0);

        // Left at column 0: off-grid neighbour, never queried.
        applyStimulus(4'b0000, 4'b1000);
        waitCycles(30);
        checkOutput("edge_req", 32'(reqCount2), 32'd0);
        checkOutput("edge_moving", 32'(mov2), 32'd0);
        checkOutput("edge_dir", 32'(dir2), 32'd0);
        checkOutput("edge_pac_x", 32'(px2), 32'd0);

        applySprite(10'd50, 10'd30, 1'b1, 5'd2, 5'd6);
        applySprite(10'd72, 10'd30, 1'b0, 5'd0, 5'd0);
        applySprite(10'd71, 10'd47, 1'b1, 5'd23, 5'd23);
        applySprite(10'd47, 10'd30, 1'b0, 5'd0, 5'd0);
        applySprite(10'd50, 10'd48, 1'b0, 5'd0, 5'd0);
        applySprite(10'd48, 10'd24, 1'b1, 5'd0, 5'd0);
        h_cnt = 10'd0;
        v_cnt = 10'd0;

        expQ.push_back('{col: 5'd13, row: 5'd15, hit: 1'b0});
        expQ.push_back('{col: 5'd14, row: 5'd15, hit: 1'b0});
        applyStimulus(4'b0010, 4'b0000);
        waitPac(10'd312, 400);
        checkOutput("run_dir", 32'(dir), 32'd2);
        checkOutput("run_moving", 32'(moving), 32'd1);
        checkOutput("run_reqs_312", 32'(reqCount), 32'd1);
        waitPac(10'd320, 100);
        checkOutput("run_reqs_320", 32'(reqCount), 32'd2);

        // Up requested mid-tile; up is walled twice, right stays open.
        expQ.push_back('{col: 5'd14, row: 5'd14, hit: 1'b1});
        expQ.push_back('{col: 5'd15, row: 5'd15, hit: 1'b0});
        expQ.push_back('{col: 5'd15, row: 5'd14, hit: 1'b1});
        expQ.push_back('{col: 5'd16, row: 5'd15, hit: 1'b0});
        applyStimulus(4'b0100, 4'b0000);
        waitPac(10'd337, 200);
        checkOutput("turn_reqs_337", 32'(reqCount), 32'd4);
        checkOutput("turn_dir", 32'(dir), 32'd2);
        checkOutput("turn_pac_y", 32'(pac_y), 32'd360);
        waitPac(10'd361, 200);
        checkOutput("turn_reqs_361", 32'(reqCount), 32'd6);
        checkOutput("turn_dir2", 32'(dir), 32'd2);
        checkOutput("turn_queue_empty", 32'(expQ.size()), 32'd0);

        // Reset while waiting for the wall answer, then a stale ack.
        autoAck = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        waitCycles(2);
        rst = 1'b0;
        expQ.push_back('{col: 5'd13, row: 5'd15, hit: 1'b0});
        applyStimulus(4'b0010, 4'b0000);
        waitReq(7, 40);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        lateAckCnt++;
        waitCycles(12);
        checkOutput("late_pac_x", 32'(pac_x), 32'd288);
        checkOutput("late_pac_y", 32'(pac_y), 32'd360);
        checkOutput("late_dir", 32'(dir), 32'd0);
        checkOutput("late_moving", 32'(moving), 32'd0);
        checkOutput("late_reqs", 32'(reqCount), 32'd7);

`ifdef PAC_REVERSE_EN
        autoAck = 1'b1;
        expQ.push_back('{col: 5'd13, row: 5'd15, hit: 1'b0});
        applyStimulus(4'b0010, 4'b0000);
        waitPac(10'd293, 200);
        applyStimulus(4'b1000, 4'b0000);
        waitPac(10'd292, 50);
        checkOutput("rev_dir", 32'(dir), 32'd8);
        checkOutput("rev_reqs", 32'(reqCount), 32'd8);
        checkOutput("rev_moving", 32'(moving), 32'd1);
        expQ.push_back('{col: 5'd11, row: 5'd15, hit: 1'b1});
        waitPac(10'd288, 100);
        waitReq(9, 40);
        waitCycles(6);
        checkOutput("rev_stop_moving", 32'(moving), 32'd0);
        checkOutput("rev_stop_pac_x", 32'(pac_x), 32'd288);
        checkOutput("rev_stop_dir", 32'(dir), 32'd8);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
